// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: fetch FSM states, IF/ID payload and
// the opcode constants the fetch logic reacts to.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam logic [5:0] HALT_OP   = 6'b111111;
   localparam word_t      NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      word_t instr;
      word_t pc4;
      logic  valid;
   } ifid_t;

   function automatic logic is_halt(input word_t instr);
      return instr[31:26] == HALT_OP;
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// Signal bundle for the fetch stage: the stage's own view and the driver view
// used by a stimulus environment.
interface ifetch_if;

   logic [31:0] pcout;
   logic        pcenable;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        flush;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        fetch_halted;

   modport ifetch (
      input  pcout, ihit, imemload, stall, flush,
      output pcenable, imemREN, imemaddr,
             ifid_instr, ifid_pc4, ifid_valid, fetch_halted
   );

   modport tb (
      output pcout, ihit, imemload, stall, flush,
      input  pcenable, imemREN, imemaddr,
             ifid_instr, ifid_pc4, ifid_valid, fetch_halted
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry skid register that parks a fetch completing while decode is
// stalled. Clear wins over load so a flush always empties it.
module fetch_skid_buf
   import cpu_types_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  load_i,
   input  logic  clear_i,
   input  ifid_t data_i,
   output logic  valid_o,
   output ifid_t data_o
);

   localparam ifid_t EMPTY = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

   logic  valid_q, valid_d;
   ifid_t data_q, data_d;

   // NOTE: every combinational output gets a default first so no path
   // through the block leaves it unassigned, which would infer a latch.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
         data_d  = EMPTY;
      end else if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   // NOTE: the payload is reset along with the flag; it is one entry, and a
   // known value keeps the drained word deterministic after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= EMPTY;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: issues imem reads from the PC, runs the ihit
// handshake, drives pcenable and owns the IF/ID register plus a skid entry.
module ifetch_stage
   import cpu_types_pkg::*;
#(
   parameter int unsigned PC_INC    = 4,
   parameter word_t       RESET_PC4 = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] pcout,
   output logic        pcenable,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc4,
   output logic        ifid_valid,
   output logic        fetch_halted
);

   fetch_state_t state_q, state_d;
   ifid_t        ifid_q, ifid_d;
   ifid_t        fetched, bubble, skid_data;
   logic         skid_valid, skid_load, skid_clear;
   logic         pc_en;

   assign fetched = '{instr: imemload, pc4: pcout + word_t'(PC_INC), valid: 1'b1};
   assign bubble  = '{instr: NOP_INSTR, pc4: ifid_q.pc4, valid: 1'b0};

   fetch_skid_buf u_skid (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (fetched),
      .valid_o (skid_valid),
      .data_o  (skid_data)
   );

   always_comb begin
      state_d    = state_q;
      ifid_d     = ifid_q;
      pc_en      = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      if (flush) begin
         // Redirect: the PC takes the new target, anything in flight is dropped.
         pc_en      = 1'b1;
         ifid_d     = bubble;
         skid_clear = 1'b1;
         state_d    = FETCH;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (ihit && !stall) begin
                  ifid_d  = fetched;
                  pc_en   = !is_halt(imemload);
                  state_d = is_halt(imemload) ? HALTED : FETCH;
               end else if (ihit) begin
                  skid_load = 1'b1;
                  pc_en     = !is_halt(imemload);
                  state_d   = HOLD;
               end else if (!stall) begin
                  ifid_d = bubble;
               end
            end
            HOLD: begin
               // Draining costs one fetch slot; no read is issued this cycle.
               if (!stall) begin
                  ifid_d     = '{instr: skid_data.instr, pc4: skid_data.pc4, valid: skid_valid};
                  skid_clear = 1'b1;
                  state_d    = is_halt(skid_data.instr) ? HALTED : FETCH;
               end
            end
            HALTED: begin
               if (!stall) begin
                  ifid_d = bubble;
               end
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= FETCH;
         ifid_q  <= '{instr: NOP_INSTR, pc4: RESET_PC4, valid: 1'b0};
      end else begin
         state_q <= state_d;
         ifid_q  <= ifid_d;
      end
   end

   // Reset leaves the FSM in FETCH, so requests are gated while RST is high.
   assign pcenable     = pc_en & ~RST;
   assign imemREN      = (state_q == FETCH) & ~RST;
   assign imemaddr     = pcout;
   assign fetch_halted = (state_q == HALTED);
   assign ifid_instr   = ifid_q.instr;
   assign ifid_pc4     = ifid_q.pc4;
   assign ifid_valid   = ifid_q.valid;

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage between the PC unit and decode.
- Drives the instruction-memory read request from the current PC and runs the ihit handshake.
- Generates pcenable back to the PC unit.
- Owns the IF/ID pipeline register plus a one-entry skid buffer, so a fetch that completes during a decode stall is not lost.
- Handles stall, flush and halt.

Parameters:
- PC_INC, 4, byte increment added to the PC to form the fall-through address.
- RESET_PC4, 32'h0000_0000, reset value of ifid_pc4.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- pcout  input  32  current PC from the PC unit.
- pcenable  output  1  PC-unit load enable.
- imemREN  output  1  instruction-memory read request.
- imemaddr  output  32  instruction-memory address.
- ihit  input  1  instruction memory returns valid data this cycle.
- imemload  input  32  instruction word from memory.
- stall  input  1  decode/hazard stall; IF/ID must hold.
- flush  input  1  redirect from branch/jump resolution; squash the younger fetch.
- ifid_instr  output  32  instruction to decode.
- ifid_pc4  output  32  PC+PC_INC of ifid_instr; feeds the PC unit's branch_pc4.
- ifid_valid  output  1  ifid_instr is a real instruction, not a bubble.
- fetch_halted  output  1  HALT has been fetched; fetch is frozen.

Behaviour:
- State register holds one of FETCH, HOLD or HALTED. Async reset puts it in FETCH.
- Reset values:
  - ifid_instr = 0 (NOP), ifid_pc4 = RESET_PC4, ifid_valid = 0.
  - Skid buffer cleared. fetch_halted = 0.
  - While RST is high: pcenable = 0 and imemREN = 0.
- imemaddr = pcout, combinational.
- fall-through address = pcout + PC_INC, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Precedence every cycle: flush > stall > normal.
- flush in any state:
  - pcenable = 1, so the PC takes the redirect.
  - IF/ID becomes a bubble: instr 0, valid 0, pc4 unchanged.
  - Skid buffer is invalidated. Any same-cycle ihit data is discarded.
  - Next state = FETCH; fetch_halted clears.
- FETCH state: imemREN = 1.
  - ihit & !stall:
    - IF/ID <= {imemload, pcout+PC_INC}, valid = 1.
    - If opcode imemload[31:26] == HALT: pcenable = 0, next state = HALTED.
    - Otherwise: pcenable = 1, stay in FETCH.
  - ihit & stall:
    - Skid buffer <= {imemload, pcout+PC_INC}; IF/ID holds.
    - pcenable = 1 unless the captured opcode is HALT.
    - Next state = HOLD.
  - !ihit & !stall: pcenable = 0; IF/ID <= bubble.
  - !ihit & stall: pcenable = 0; IF/ID holds.
- HOLD state: imemREN = 0, pcenable = 0.
  - stall: IF/ID and buffer hold.
  - !stall: IF/ID <= buffer with valid = 1; buffer cleared.
    - Next state = HALTED if the buffered opcode is HALT, else FETCH.
  - No new fetch is issued in the cycle the buffer drains. This is a one-cycle refill penalty, by design.
- HALTED state: imemREN = 0, pcenable = 0, fetch_halted = 1.
  - IF/ID holds while stall; becomes a bubble once !stall.
  - Leaves only on flush (the HALT was on a wrong path) or on RST.
- The PC must never advance without the corresponding instruction being in IF/ID or the skid buffer. Exception: the flush redirect.
- RST asserted mid-request abandons the outstanding read with no side effects.

Decomposition:
- cpu_types_pkg additions:
  - fetch_state_t enum {FETCH, HOLD, HALTED}.
  - HALT opcode constant 6'b111111.
  - NOP_INSTR = 32'h0.
  - ifid_t packed struct {word_t instr; word_t pc4; logic valid}.
- Signals bundle in new interface ifetch_if.vh with modports ifetch and tb.
- One sub-module, fetch_skid_buf: a single-entry ifid_t register with load/drain/clear controls and a valid flag. The FSM and IF/ID register stay in ifetch_stage.

Test Plan:
- Reset with pcout = 0, then ihit = 1 each cycle, imemload = 32'h2001_0005, no stall → next edge ifid_instr = 32'h2001_0005, ifid_pc4 = 4, ifid_valid = 1; pcenable = 1 on every hit cycle.
- ihit = 0 for 3 cycles with stall = 0 → pcenable = 0, imemREN = 1, ifid_valid = 0 for those cycles; IF/ID loads on the first ihit.
- stall = 1 while ihit delivers 32'h8C22_0000 at pcout = 32'h40 → state HOLD, IF/ID unchanged, pcenable pulses once. Drop stall → ifid_instr = 32'h8C22_0000, ifid_pc4 = 32'h44; imemREN = 0 for that one cycle.
- flush and stall both high, with ihit and a valid skid buffer → pcenable = 1, ifid_valid = 0, ifid_instr = 0, buffer dropped, state FETCH.
- ihit with imemload = 32'hFFFF_FFFF (HALT) → pcenable = 0, fetch_halted = 1, imemREN = 0 thereafter. Later flush → fetch_halted = 0 and fetching resumes. RST mid-HOLD → all outputs return to reset values asynchronously.
- pcout = 32'hFFFF_FFFC with ihit → ifid_pc4 = 32'h0000_0000.
